// File: rtl/proc_core_param.sv
// Parametrised register/ALU/control core with a multi-cycle FSM, valid/ready instruction,
// IN and OUT handshakes, and a sticky HALT. Optional macro PROC_R0_ZERO_EN hardwires regs[0] to 0.
module proc_core_param #(
    parameter int  DATA_W   = 8,
    parameter int  NUM_REGS = 8,
    localparam int REG_AW   = $clog2(NUM_REGS),
    localparam int INSTR_W  = 5 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               done,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               sign_flag,
    output logic               overflow_flag,
    output logic               halted,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_WB       = 3'd2,
        S_IN_WAIT  = 3'd3,
        S_OUT_WAIT = 3'd4,
        S_HALTED   = 3'd5
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_GT   = 5'd8;
    localparam logic [4:0] OP_LT   = 5'd9;
    localparam logic [4:0] OP_EQ   = 5'd10;
    localparam logic [4:0] OP_NE   = 5'd11;
    localparam logic [4:0] OP_MOV  = 5'd12;
    localparam logic [4:0] OP_SHL  = 5'd13;
    localparam logic [4:0] OP_SHR  = 5'd14;
    localparam logic [4:0] OP_IN   = 5'd15;
    localparam logic [4:0] OP_OUT  = 5'd16;
    localparam logic [4:0] OP_HALT = 5'd17;
    localparam logic [4:0] OP_NOP0 = 5'd18;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [INSTR_W-1:0]  instr_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [DATA_W-1:0]   wb_data_r;
    logic                wb_we_r;
    logic                wb_fl_r;
    logic                zf_p_r, cf_p_r, sf_p_r, vf_p_r;
    logic [DATA_W-1:0]   result_r;
    logic                zero_r, carry_r, sign_r, ovf_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic                done_r;
    logic                halted_r;

    logic [4:0]          op_s, op_in_s;
    logic [REG_AW-1:0]   rd_s, rs_s, rt_s, rs_in_s;
    logic [DATA_W-1:0]   a_s, b_s;
    logic [DATA_W:0]     sum_s, diff_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_c_s, alu_v_s;
    logic                flag_op_s;
    logic                reg_we_s;

    assign op_s    = instr_r[INSTR_W-1 -: 5];
    assign rd_s    = instr_r[3*REG_AW-1 -: REG_AW];
    assign rs_s    = instr_r[2*REG_AW-1 -: REG_AW];
    assign rt_s    = instr_r[REG_AW-1:0];
    assign op_in_s = instr[INSTR_W-1 -: 5];
    assign rs_in_s = instr[2*REG_AW-1 -: REG_AW];

    assign a_s    = regs_r[rs_s];
    assign b_s    = regs_r[rt_s];
    assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
    assign diff_s = {1'b0, a_s} - {1'b0, b_s};
    assign prod_s = {{DATA_W{1'b0}}, a_s} * {{DATA_W{1'b0}}, b_s};

    assign flag_op_s = (op_s <= OP_NE) || (op_s == OP_SHL) || (op_s == OP_SHR);

    // ALU result with carry/overflow; the MSB of diff_s is the borrow out
    always_comb begin
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op_s)
            OP_ADD: begin
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
                alu_v_s   = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (alu_res_s[DATA_W-1] != a_s[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[DATA_W-1:0];
                alu_c_s   = diff_s[DATA_W];
                alu_v_s   = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (alu_res_s[DATA_W-1] != a_s[DATA_W-1]);
            end
            OP_MUL: begin
                alu_res_s = prod_s[DATA_W-1:0];
                alu_c_s   = |prod_s[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                if (b_s == '0) alu_res_s = '1;
                else           alu_res_s = a_s / b_s;
            end
            OP_MOD: begin
                if (b_s == '0) alu_res_s = a_s;
                else           alu_res_s = a_s % b_s;
            end
            OP_AND: alu_res_s = a_s & b_s;
            OP_OR:  alu_res_s = a_s | b_s;
            OP_XOR: alu_res_s = a_s ^ b_s;
            OP_GT:  alu_res_s = {{(DATA_W-1){1'b0}}, (a_s > b_s)};
            OP_LT:  alu_res_s = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_EQ:  alu_res_s = {{(DATA_W-1){1'b0}}, (a_s == b_s)};
            OP_NE:  alu_res_s = {{(DATA_W-1){1'b0}}, (a_s != b_s)};
            OP_MOV: alu_res_s = a_s;
            OP_SHL: begin
                alu_res_s = {a_s[DATA_W-2:0], 1'b0};
                alu_c_s   = a_s[DATA_W-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, a_s[DATA_W-1:1]};
                alu_c_s   = a_s[0];
            end
            default: alu_res_s = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (instr_valid) begin
                    if      (op_in_s == OP_IN)   state_nxt_s = S_IN_WAIT;
                    else if (op_in_s == OP_OUT)  state_nxt_s = S_OUT_WAIT;
                    else if (op_in_s == OP_HALT) state_nxt_s = S_HALTED;
                    else if (op_in_s >= OP_NOP0) state_nxt_s = S_WB;
                    else                         state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EXEC:     state_nxt_s = S_WB;
            S_WB:       state_nxt_s = S_IDLE;
            S_IN_WAIT: begin
                if (in_valid) state_nxt_s = S_WB;
                else          state_nxt_s = S_IN_WAIT;
            end
            S_OUT_WAIT: begin
                if (out_ready) state_nxt_s = S_WB;
                else           state_nxt_s = S_OUT_WAIT;
            end
            S_HALTED:   state_nxt_s = S_HALTED;
            default:    state_nxt_s = S_IDLE;
        endcase
    end

    // Instruction latch, pending write-back, flags and port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r     <= '0;
            wb_data_r   <= '0;
            wb_we_r     <= 1'b0;
            wb_fl_r     <= 1'b0;
            zf_p_r      <= 1'b0;
            cf_p_r      <= 1'b0;
            sf_p_r      <= 1'b0;
            vf_p_r      <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            sign_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_r <= instr;
                        wb_we_r <= 1'b0;
                        wb_fl_r <= 1'b0;
                        if (op_in_s == OP_OUT) begin
                            out_data_r  <= regs_r[rs_in_s];
                            out_valid_r <= 1'b1;
                        end
                        if (op_in_s == OP_HALT) halted_r <= 1'b1;
                        if (op_in_s >= OP_NOP0) done_r <= 1'b1;
                    end
                end
                S_EXEC: begin
                    wb_data_r <= alu_res_s;
                    wb_we_r   <= 1'b1;
                    wb_fl_r   <= flag_op_s;
                    zf_p_r    <= (alu_res_s == '0);
                    cf_p_r    <= alu_c_s;
                    sf_p_r    <= alu_res_s[DATA_W-1];
                    vf_p_r    <= alu_v_s;
                    done_r    <= 1'b1;
                end
                S_IN_WAIT: begin
                    if (in_valid) begin
                        wb_data_r <= in_data;
                        wb_we_r   <= 1'b1;
                        wb_fl_r   <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        wb_we_r     <= 1'b0;
                        wb_fl_r     <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_we_r) result_r <= wb_data_r;
                    if (wb_fl_r) begin
                        zero_r  <= zf_p_r;
                        carry_r <= cf_p_r;
                        sign_r  <= sf_p_r;
                        ovf_r   <= vf_p_r;
                    end
                end
                S_HALTED: halted_r <= 1'b1;
                default:  done_r   <= 1'b0;
            endcase
        end
    end

`ifdef PROC_R0_ZERO_EN
    assign reg_we_s = (state_r == S_WB) && wb_we_r && (rd_s != '0);
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_r[dbg_addr];
`else
    assign reg_we_s = (state_r == S_WB) && wb_we_r;
    assign dbg_data = regs_r[dbg_addr];
`endif

    // Register file
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
        end else if (reg_we_s) begin
            regs_r[rd_s] <= wb_data_r;
        end
    end

    assign instr_ready   = (state_r == S_IDLE);
    assign in_ready      = (state_r == S_IN_WAIT);
    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign result        = result_r;
    assign done          = done_r;
    assign zero_flag     = zero_r;
    assign carry_flag    = carry_r;
    assign sign_flag     = sign_r;
    assign overflow_flag = ovf_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_proc_core_param.sv
// Directed plus randomized bench for proc_core_param against an arithmetic reference model.
module tb_proc_core_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] instr;
    logic        instr_valid, instr_ready;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;
    logic [7:0]  result;
    logic        done, zero_flag, carry_flag, sign_flag, overflow_flag, halted;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int total = 0;
    int bad   = 0;
    int m_regs [8];
    int m_res, m_z, m_c, m_s, m_v;

    proc_core_param #(.DATA_W(8), .NUM_REGS(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .done(done),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .sign_flag(sign_flag),
        .overflow_flag(overflow_flag), .halted(halted),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sval(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_res = 0; m_z = 0; m_c = 0; m_s = 0; m_v = 0;
    endfunction

    function automatic void m_write(input int rd, input int val);
`ifdef PROC_R0_ZERO_EN
        if (rd != 0) m_regs[rd] = val;
`else
        m_regs[rd] = val;
`endif
        m_res = val;
    endfunction

    // Reference behaviour of one ALU/MOV/NOP instruction
    function automatic void m_exec(input int op, input int rd, input int rs, input int rt);
        int a, b, full, r, c, v;
        a = m_regs[rs]; b = m_regs[rt]; c = 0; v = 0; r = 0;
        if (op > 14) return;
        case (op)
            0:  begin full = a + b; r = full % 256; c = int'(full > 255);
                      full = sval(a) + sval(b); v = int'(full > 127 || full < -128); end
            1:  begin r = (a - b + 256) % 256; c = int'(a < b);
                      full = sval(a) - sval(b); v = int'(full > 127 || full < -128); end
            2:  begin full = a * b; r = full % 256; c = int'(full > 255); end
            3:  r = (b == 0) ? 255 : a / b;
            4:  r = (b == 0) ? a : a % b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = int'(a > b);
            9:  r = int'(a < b);
            10: r = int'(a == b);
            11: r = int'(a != b);
            12: r = a;
            13: begin r = (a * 2) % 256; c = int'(a >= 128); end
            14: begin r = a / 2; c = a % 2; end
            default: r = 0;
        endcase
        m_write(rd, r);
        if (op != 12) begin
            m_z = int'(r == 0); m_s = int'(r >= 128); m_c = c; m_v = v;
        end
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), {24'd0, dbg_data}, m_regs[i]);
        end
        chk({tag, "_result"}, {24'd0, result}, m_res);
        chk({tag, "_zero"}, {31'd0, zero_flag}, m_z);
        chk({tag, "_carry"}, {31'd0, carry_flag}, m_c);
        chk({tag, "_sign"}, {31'd0, sign_flag}, m_s);
        chk({tag, "_ovf"}, {31'd0, overflow_flag}, m_v);
    endtask

    task automatic accept(input int op, input int rd, input int rs, input int rt);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
        instr = {5'(op), 3'(rd), 3'(rs), 3'(rt)};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic run_instr(input int op, input int rd, input int rs, input int rt, input int lat);
        int cnt;
        accept(op, rd, rs, rt);
        cnt = 1;
        while (done !== 1'b1 && cnt < 12) begin
            @(posedge clk); #1; cnt++;
        end
        chk($sformatf("latency_op%0d", op), cnt, lat);
        @(posedge clk); #1;
        chk("done_single", {31'd0, done}, 32'd0);
        chk("ready_after", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic do_in(input int rd, input int val);
        in_data = 8'(val);
        in_valid = 1'b1;
        run_instr(15, rd, 0, 0, 2);
        in_valid = 1'b0;
        m_write(rd, val);
    endtask

    task automatic alu(input int op, input int rd, input int rs, input int rt);
        run_instr(op, rd, rs, rt, (op >= 18) ? 1 : 2);
        m_exec(op, rd, rs, rt);
        check_state($sformatf("op%0d", op));
    endtask

    initial begin
        int op, exp_out;
        rst = 1'b1; instr = '0; instr_valid = 1'b0; in_data = '0; in_valid = 1'b0;
        out_ready = 1'b1; dbg_addr = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        rst = 1'b0;

        do_in(0, 5); do_in(1, 3);
        alu(0, 2, 0, 1);

        do_in(4, 8'h7F); do_in(5, 8'h01);
        alu(0, 6, 4, 5);
        chk("ovf_add_result", {24'd0, result}, 32'h80);
        chk("ovf_add_sign", {31'd0, sign_flag}, 32'd1);
        chk("ovf_add_ovf", {31'd0, overflow_flag}, 32'd1);
        chk("ovf_add_carry", {31'd0, carry_flag}, 32'd0);
        do_in(4, 8'hFF);
        alu(0, 6, 4, 5);
        chk("wrap_add_result", {24'd0, result}, 32'h00);
        chk("wrap_add_zero", {31'd0, zero_flag}, 32'd1);
        chk("wrap_add_carry", {31'd0, carry_flag}, 32'd1);

        do_in(5, 0); do_in(4, 9);
        alu(3, 6, 4, 5);
        chk("div0_result", {24'd0, result}, 32'hFF);
        alu(4, 7, 4, 5);
        chk("mod0_result", {24'd0, result}, 32'h09);

        for (int i = 0; i < 8; i++) do_in(i, $urandom_range(0, 255));
        for (int i = 0; i < 40; i++) begin
            op = (i % 10 == 9) ? $urandom_range(18, 31) : $urandom_range(0, 14);
            alu(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        end

        // OUT with the sink stalled for four cycles
        do_in(2, 8);
        out_ready = 1'b0;
        exp_out = m_regs[2];
        accept(16, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            chk("out_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("out_hold_data", {24'd0, out_data}, exp_out);
            chk("out_hold_ready", {31'd0, instr_ready}, 32'd0);
            chk("out_hold_done", {31'd0, done}, 32'd0);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("out_hs_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        chk("out_after_done", {31'd0, done}, 32'd0);
        chk("out_after_ready", {31'd0, instr_ready}, 32'd1);
        check_state("out");

        alu(12, 0, 2, 0);

        // HALT is sticky until reset
        accept(17, 0, 0, 0);
        instr = {5'd0, 3'd3, 3'd2, 3'd2};
        instr_valid = 1'b1;
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_ready", {31'd0, instr_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("halt_ready_hold", {31'd0, instr_ready}, 32'd0);
            chk("halt_hold", {31'd0, halted}, 32'd1);
            chk("halt_done", {31'd0, done}, 32'd0);
        end
        check_state("halted");
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_ready", {31'd0, instr_ready}, 32'd1);
        check_state("unhalt");

        // Reset while OUT is pending
        do_in(3, 8'hA5);
        out_ready = 1'b0;
        accept(16, 0, 3, 0);
        chk("rst_out_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_out_done", {31'd0, done}, 32'd0);
        chk("rst_out_valid2", {31'd0, out_valid}, 32'd0);
        check_state("rst_out");
        out_ready = 1'b1;

        // Reset while an ADD is in EXEC
        do_in(1, 8'h11); do_in(2, 8'h22);
        accept(0, 3, 1, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        chk("rst_exec_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_exec_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("rst_exec_done2", {31'd0, done}, 32'd0);
        check_state("rst_exec");

        do_in(1, 8'h40); do_in(2, 8'hC0);
        alu(1, 3, 1, 2);
        alu(13, 4, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_core_param.md
Name: proc_core_param

Overview:
- Parametrised successor of the 8-bit register/ALU/control processor.
- Adds the following:
  - configurable data width and register count;
  - synchronous reset;
  - a multi-cycle FSM with valid/ready instruction handshake;
  - registered flags;
  - handshaked IN/OUT ports;
  - a sticky HALT state.
- Sits between the instruction source (testbench or fetch unit) and the I/O peripherals.
- Holds its own register file, ALU and controller.

Parameters:
- DATA_W, 8: datapath and register width (>=4).
- NUM_REGS, 8: register count. Power of 2, >=2. REG_AW = log2(NUM_REGS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  5+3*REG_AW  instruction, packed as {opcode[4:0], rd, rs, rt}.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  core accepts an instruction this cycle.
- in_data  in  DATA_W  input-port data.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core consumes in_data.
- out_data  out  DATA_W  output-port data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.
- result  out  DATA_W  last ALU/MOV/IN result written.
- done  out  1  one-cycle pulse when an instruction retires.
- zero_flag, carry_flag, sign_flag, overflow_flag  out  1 each  registered flags.
- halted  out  1  core is in HALTED.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational read of regs[dbg_addr].

Behaviour:
- Reset values: every register = 0; result = 0; all flags = 0; out_data = 0; out_valid = 0; done = 0; halted = 0; state = IDLE. Reset wins over any simultaneous event and aborts any in-flight instruction, including a pending OUT.
- FSM states: IDLE, EXEC, WB, IN_WAIT, OUT_WAIT, HALTED.
  - IDLE: instr_ready = 1. On instr_valid, latch instr.
    - opcode 15 -> IN_WAIT.
    - opcode 16 -> OUT_WAIT; out_data <= regs[rs], out_valid <= 1.
    - opcode 17 -> HALTED.
    - opcodes 18-31 (NOP) -> WB, with no register or flag write.
    - all other opcodes -> EXEC.
  - EXEC: compute from regs[rs] and regs[rt]; register the result and new flags; -> WB.
  - WB: write regs[rd] and result; update flags for ALU ops; done = 1; -> IDLE.
  - IN_WAIT: in_ready = 1. On in_valid: regs[rd] <= in_data, result <= in_data, done = 1 in the following cycle (via WB, flags preserved).
  - OUT_WAIT: hold out_valid and out_data until out_ready. On the handshake, out_valid <= 0 -> WB (done pulse, no write).
  - HALTED: halted = 1, instr_ready = 0. Exit only by rst.
- instr_ready is 0 in every state except IDLE.
- ALU op latency: accept at edge E0, result registered at E1, regs[rd] and flags visible after E2, done high during the WB cycle (E1 to E2). Throughput: one instruction per 3 cycles.
- Opcodes (A = regs[rs], B = regs[rt]):
  - 0 ADD, 1 SUB.
  - 2 MUL: low DATA_W bits kept.
  - 3 DIV, 4 MOD: unsigned. B = 0 gives DIV = all ones, MOD = A.
  - 5 AND, 6 OR, 7 XOR.
  - 8 GT, 9 LT: unsigned, result 1 or 0.
  - 10 EQ, 11 NE: result 1 or 0.
  - 12 MOV: rd <= A.
  - 13 SHL: A<<1.
  - 14 SHR: A>>1.
- Flags are updated only by opcodes 0-11, 13 and 14. MOV, IN, OUT and NOP preserve all flags.
  - zero = (res == 0).
  - sign = res[DATA_W-1].
  - carry:
    - ADD: carry-out.
    - SUB: borrow (A < B).
    - MUL: any discarded high bit nonzero.
    - SHL: A[MSB].
    - SHR: A[0].
    - all other ops: 0.
  - overflow (signed):
    - ADD: A and B have the same sign and res sign differs.
    - SUB: A and B signs differ and res sign differs from A.
    - all other ops: 0.
- rd = rs is legal. The read happens in EXEC, before the write in WB.

Optional Feature:
- Macro: PROC_R0_ZERO_EN.
- Defined: regs[0] is hardwired to 0. Writes to rd = 0 are discarded. result and flags still update. dbg_data reads 0 for address 0.
- Undefined: regs[0] is an ordinary register.

Test Plan:
- Reset, then IN rd=0 with 5, IN rd=1 with 3, ADD rd=2 rs=0 rt=1 -> done two cycles after acceptance; regs[2] = 8, all flags 0.
- regs0 = 0x7F, regs1 = 0x01, ADD -> result 0x80, sign = 1, overflow = 1, carry = 0. Then 0xFF + 0x01 -> result 0x00, zero = 1, carry = 1.
- DIV and MOD with regs1 = 0 and regs0 = 9 -> DIV 0xFF, MOD 0x09, no hang; done pulses once per instruction.
- OUT rs=2 with out_ready held low 4 cycles -> out_valid stays high and out_data is stable; instr_ready stays 0; done follows the handshake by one cycle.
- HALT then instr_valid = 1 with ADD -> instr_ready = 0, halted = 1, registers unchanged; rst pulse -> IDLE and all registers 0.
- Assert rst during OUT_WAIT and during EXEC -> out_valid = 0 next cycle, no register write, state IDLE. With PROC_R0_ZERO_EN, MOV rd=0 rs=2 (regs2 = 8) -> dbg_data at address 0 reads 0.
